// File: rtl/capturador_clave_teclado.sv
// rtl/capturador_clave_teclado.sv - keypad front-end assembling a 4-digit BCD password word
// Optional feature macro: BACKSPACE_EN (code 0xC deletes the last digit)
module capturador_clave_teclado #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TMR_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sensor_vehicule,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] password_input,
    output logic        password_valid,
    output logic [2:0]  digit_count,
    output logic        entry_busy,
    output logic        key_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      buf_q, buf_d;
    logic [2:0]       count_q, count_d;
    logic [15:0]      pw_q, pw_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             busy_q;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             expired;

    assign expired = (TIMEOUT_CYCLES != 0) && (count_q != 3'd0) &&
                     (timer_q == TMR_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_q   <= 16'h0000;
            count_q <= 3'd0;
            pw_q    <= 16'h0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            pw_q    <= pw_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        count_d = count_q;
        pw_d    = pw_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (key_valid || count_q == 3'd0 || expired) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sensor_vehicule) begin
                    state_d = COLLECT;
                end
            end
            COLLECT, FULL: begin
                if (!sensor_vehicule) begin
                    state_d = IDLE;
                    buf_d   = 16'h0000;
                    count_d = 3'd0;
                end else begin
                    // Expiry clears first so a coincident key sees the empty buffer.
                    if (expired) begin
                        state_d = COLLECT;
                        buf_d   = 16'h0000;
                        count_d = 3'd0;
                    end
                    if (key_valid) begin
                        if (key_code <= 4'd9) begin
                            if (state_d == FULL) begin
                                err_d = 1'b1;
                            end else begin
                                buf_d   = {buf_d[11:0], key_code};
                                count_d = count_d + 3'd1;
                                if (count_d == 3'd4) begin
                                    state_d = FULL;
                                end
                            end
                        end else begin
                            case (key_code)
                                4'hA: begin
                                    state_d = COLLECT;
                                    buf_d   = 16'h0000;
                                    count_d = 3'd0;
                                end
                                4'hB: begin
                                    if (state_d == FULL) begin
                                        state_d = SEND;
                                        pw_d    = buf_d;
                                        valid_d = 1'b1;
                                    end else begin
                                        err_d   = 1'b1;
                                        buf_d   = 16'h0000;
                                        count_d = 3'd0;
                                    end
                                end
                                4'hC: begin
`ifdef BACKSPACE_EN
                                    if (count_d == 3'd0) begin
                                        err_d = 1'b1;
                                    end else begin
                                        buf_d   = {4'h0, buf_d[15:4]};
                                        count_d = count_d - 3'd1;
                                        state_d = COLLECT;
                                    end
`else
                                    err_d = 1'b1;
`endif
                                end
                                default: err_d = 1'b1;
                            endcase
                        end
                    end
                end
            end
            SEND: begin
                buf_d   = 16'h0000;
                count_d = 3'd0;
                state_d = sensor_vehicule ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign password_input = pw_q;
    assign password_valid = valid_q;
    assign digit_count    = count_q;
    assign entry_busy     = busy_q;
    assign key_error      = err_q;

endmodule
